mem_stage: RTL and testbench

//  Memory-access pipeline stage directly downstream of EX. Registers ex_to_mem_bus under stall

---
 rtl/mem_stage.sv | 113 +++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bundle under stall control and extracts/extends
// load data from the SRAM read port, holding the read word while the stage is stalled.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 148,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_ID_WD = 104
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [1:0]              ex_addr_lo,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} hold_state_e;

    logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
    logic [1:0]              addr_lo_q, addr_lo_d;
    hold_state_e             state_q, state_d;
    logic [31:0]             hold_data_q, hold_data_d;
    logic                    hold_valid;

    logic [31:0] pc, ex_result, hi, lo;
    logic        sram_en, sel_rf_res, hi_we, lo_we, rf_we;
    logic [3:0]  sram_wen;
    logic [4:0]  rf_waddr;
    logic [5:0]  op;
    logic        is_load;
    logic [31:0] word, load_data, rf_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_stall;

    assign {pc, sram_en, sram_wen, sel_rf_res, hi_we, lo_we, rf_we,
            rf_waddr, op, ex_result, hi, lo} = bus_q;
    assign is_load      = sram_en && (sram_wen == 4'b0000);
    assign unused_stall = ^{stall[5], stall[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q       <= '0;
            addr_lo_q   <= '0;
            state_q     <= EMPTY;
            hold_data_q <= '0;
        end else begin
            bus_q       <= bus_d;
            addr_lo_q   <= addr_lo_d;
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
        end
    end

    // stall[3] low: advance; stall[3] high with stall[4] low: EX stalled, MEM drains as a bubble.
    always_comb begin
        bus_d     = bus_q;
        addr_lo_d = addr_lo_q;
        if (!stall[3]) begin
            bus_d     = ex_to_mem_bus;
            addr_lo_d = ex_addr_lo;
        end else if (!stall[4]) begin
            bus_d     = '0;
            addr_lo_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        case (state_q)
            EMPTY: begin
                if (is_load && stall[3] && stall[4]) begin
                    state_d     = HELD;
                    hold_data_d = data_sram_rdata;
                end
            end
            HELD: begin
                if (!(stall[3] && stall[4])) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        hold_valid = (state_q == HELD);
    end

    always_comb begin
        word     = hold_valid ? hold_data_q : data_sram_rdata;
        byte_sel = word[8*addr_lo_q +: 8];
        half_sel = addr_lo_q[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            OP_LW:   load_data = word;
            default: load_data = word;
        endcase
        rf_wdata      = sel_rf_res ? load_data : ex_result;
        mem_to_wb_bus = {pc, hi_we, lo_we, rf_we, rf_waddr, rf_wdata, hi, lo};
        mem_to_id_bus = {rf_we, rf_waddr, rf_wdata, hi_we, lo_we, hi, lo};
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver pushes hand-computed expected buses into a queue,
// a monitor pops and compares each time the driver signals a sample point.
module tb_mem_stage;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] STALL_HOLD   = 6'b011111;
  localparam logic [5:0] STALL_BUBBLE = 6'b001000;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [147:0] ex_bus;
  logic [1:0]   ex_addr_lo;
  logic [31:0]  rdata;
  logic [135:0] wb_bus;
  logic [103:0] id_bus;

  logic [239:0] exp_q[$];
  string        name_q[$];
  event         mon_ev;
  int           checks = 0;
  int           errors = 0;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_to_mem_bus  (ex_bus),
    .ex_addr_lo     (ex_addr_lo),
    .data_sram_rdata(rdata),
    .mem_to_wb_bus  (wb_bus),
    .mem_to_id_bus  (id_bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [147:0] mk_ex(input logic [31:0] pc, input logic en,
                                         input logic [3:0] wen, input logic sel,
                                         input logic hw, input logic lw_, input logic rw,
                                         input logic [4:0] wa, input logic [5:0] op,
                                         input logic [31:0] res, input logic [31:0] hi,
                                         input logic [31:0] lo);
    return {pc, en, wen, sel, hw, lw_, rw, wa, op, res, hi, lo};
  endfunction

  function automatic logic [147:0] mk_ld(input logic [31:0] pc, input logic [4:0] wa,
                                         input logic [5:0] op);
    return mk_ex(pc, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, wa, op, 32'h0000_1234, 32'h0, 32'h0);
  endfunction

  // driver tasks
  task automatic issue(input logic [147:0] bus, input logic [1:0] a);
    stall      = 6'b000000;
    ex_bus     = bus;
    ex_addr_lo = a;
    @(posedge clk);
    #1;
    ex_bus     = '0;
    ex_addr_lo = 2'b00;
  endtask

  task automatic exp_out(input logic [31:0] pc, input logic hw, input logic lw_,
                         input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] hi, input logic [31:0] lo, input string nm);
    logic [135:0] ew;
    logic [103:0] ei;
    ew = {pc, hw, lw_, rw, wa, wd, hi, lo};
    ei = {rw, wa, wd, hw, lw_, hi, lo};
    exp_q.push_back({ew, ei});
    name_q.push_back(nm);
    #1;
    -> mon_ev;
    #1;
  endtask

  task automatic exp_zero(input string nm);
    exp_out(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, nm);
  endtask

  // scoreboard monitor
  initial begin
    logic [239:0] e;
    string        nm;
    forever begin
      @(mon_ev);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_without_expectation");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (wb_bus !== e[239:104]) begin
          errors++;
          $display("FAIL %s wb: got %h expected %h", nm, wb_bus, e[239:104]);
        end
        checks++;
        if (id_bus !== e[103:0]) begin
          errors++;
          $display("FAIL %s id: got %h expected %h", nm, id_bus, e[103:0]);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    stall      = 6'b000000;
    ex_bus     = '0;
    ex_addr_lo = 2'b00;
    rdata      = 32'h0;
    @(posedge clk);
    #1;
    ex_bus = mk_ld(32'h44, 5'd4, OP_LW);
    rdata  = 32'h5555_AAAA;
    exp_zero("reset_state");
    #2;
    rst = 1'b0;
    ex_bus = '0;

    // byte loads
    issue(mk_ld(32'h100, 5'd5, OP_LB), 2'd2);
    rdata = 32'h1280_FF00;
    exp_out(32'h100, 0, 0, 1, 5'd5, 32'hFFFF_FF80, 0, 0, "lb_a2");
    issue(mk_ld(32'h104, 5'd5, OP_LBU), 2'd2);
    rdata = 32'h1280_FF00;
    exp_out(32'h104, 0, 0, 1, 5'd5, 32'h0000_0080, 0, 0, "lbu_a2");
    issue(mk_ld(32'h108, 5'd6, OP_LB), 2'd1);
    rdata = 32'h1280_FF00;
    exp_out(32'h108, 0, 0, 1, 5'd6, 32'hFFFF_FFFF, 0, 0, "lb_a1");
    issue(mk_ld(32'h10C, 5'd6, OP_LBU), 2'd3);
    rdata = 32'h1280_FF00;
    exp_out(32'h10C, 0, 0, 1, 5'd6, 32'h0000_0012, 0, 0, "lbu_a3");

    // half and word loads
    issue(mk_ld(32'h110, 5'd7, OP_LH), 2'd2);
    rdata = 32'h8001_7FFF;
    exp_out(32'h110, 0, 0, 1, 5'd7, 32'hFFFF_8001, 0, 0, "lh_a2");
    issue(mk_ld(32'h114, 5'd7, OP_LHU), 2'd0);
    rdata = 32'h8001_7FFF;
    exp_out(32'h114, 0, 0, 1, 5'd7, 32'h0000_7FFF, 0, 0, "lhu_a0");
    issue(mk_ld(32'h118, 5'd7, OP_LHU), 2'd3);
    rdata = 32'h8001_7FFF;
    exp_out(32'h118, 0, 0, 1, 5'd7, 32'h0000_8001, 0, 0, "lhu_a3");
    issue(mk_ld(32'h11C, 5'd8, OP_LW), 2'd3);
    rdata = 32'h8001_7FFF;
    exp_out(32'h11C, 0, 0, 1, 5'd8, 32'h8001_7FFF, 0, 0, "lw_a3");
    issue(mk_ex(32'h120, 0, 4'b0000, 1, 0, 0, 1, 5'd9, OP_ADD, 32'h0000_0042, 0, 0), 2'd1);
    rdata = 32'h1357_9BDF;
    exp_out(32'h120, 0, 0, 1, 5'd9, 32'h1357_9BDF, 0, 0, "raw_word");

    // held load
    issue(mk_ld(32'h200, 5'd7, OP_LW), 2'd0);
    stall = STALL_HOLD;
    rdata = 32'hCAFE_F00D;
    exp_out(32'h200, 0, 0, 1, 5'd7, 32'hCAFE_F00D, 0, 0, "held_first");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rdata = 32'hDEAD_BEEF;
      exp_out(32'h200, 0, 0, 1, 5'd7, 32'hCAFE_F00D, 0, 0, "held_stall");
    end
    issue(mk_ex(32'h204, 0, 4'b0000, 0, 0, 0, 1, 5'd8, OP_ADD, 32'h0000_0055, 0, 0), 2'd0);
    rdata = 32'hDEAD_BEEF;
    exp_out(32'h204, 0, 0, 1, 5'd8, 32'h0000_0055, 0, 0, "held_release");
    issue(mk_ld(32'h208, 5'd9, OP_LW), 2'd0);
    rdata = 32'h1111_2222;
    exp_out(32'h208, 0, 0, 1, 5'd9, 32'h1111_2222, 0, 0, "hold_cleared");

    // bubbles
    issue(mk_ex(32'h300, 0, 4'b0000, 0, 0, 0, 1, 5'd2, OP_ADD, 32'h0000_7777, 0, 0), 2'd0);
    exp_out(32'h300, 0, 0, 1, 5'd2, 32'h0000_7777, 0, 0, "alu");
    stall = STALL_BUBBLE;
    @(posedge clk);
    #1;
    exp_zero("bubble");
    issue(mk_ld(32'h310, 5'd3, OP_LW), 2'd0);
    stall = STALL_HOLD;
    rdata = 32'hAAAA_5555;
    exp_out(32'h310, 0, 0, 1, 5'd3, 32'hAAAA_5555, 0, 0, "pre_bubble_load");
    @(posedge clk);
    #1;
    stall = STALL_BUBBLE;
    @(posedge clk);
    #1;
    exp_zero("bubble_from_held");
    issue(mk_ld(32'h314, 5'd3, OP_LW), 2'd0);
    rdata = 32'h1234_5678;
    exp_out(32'h314, 0, 0, 1, 5'd3, 32'h1234_5678, 0, 0, "after_bubble");

    // store and mult passthrough
    issue(mk_ex(32'h320, 1, 4'b1111, 0, 0, 0, 0, 5'd3, 6'b101011, 32'h0000_ABCD, 0, 0), 2'd1);
    rdata = 32'hFFFF_FFFF;
    exp_out(32'h320, 0, 0, 0, 5'd3, 32'h0000_ABCD, 0, 0, "store");
    issue(mk_ex(32'h330, 0, 4'b0000, 0, 1, 1, 0, 5'd0, 6'b011000, 32'h0, 32'h1, 32'h2), 2'd0);
    exp_out(32'h330, 1, 1, 0, 5'd0, 32'h0, 32'h1, 32'h2, "mult");

    // asynchronous reset while HELD
    issue(mk_ld(32'h340, 5'd10, OP_LW), 2'd0);
    stall = STALL_HOLD;
    rdata = 32'hCAFE_F00D;
    exp_out(32'h340, 0, 0, 1, 5'd10, 32'hCAFE_F00D, 0, 0, "pre_reset_load");
    @(posedge clk);
    #1;
    rdata = 32'hDEAD_BEEF;
    exp_out(32'h340, 0, 0, 1, 5'd10, 32'hCAFE_F00D, 0, 0, "pre_reset_held");
    #4;
    rst = 1'b1;
    #1;
    exp_zero("reset_mid_cycle");
    #2;
    rst = 1'b0;
    issue(mk_ld(32'h350, 5'd11, OP_LW), 2'd0);
    rdata = 32'h0BAD_F00D;
    exp_out(32'h350, 0, 0, 1, 5'd11, 32'h0BAD_F00D, 0, 0, "post_reset_live");

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
